// File: rtl/sdio_pkg.sv
// sdio_pkg: register map, status bit positions and FSM encodings shared by the SDIO SPI controller.
package sdio_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;
  localparam int ST_BUSY = 7;
  localparam int ST_CS   = 6;
  localparam logic [2:0] BUS_IDLE   = 3'd0;
  localparam logic [2:0] BUS_DECODE = 3'd1;
  localparam logic [2:0] BUS_WAIT   = 3'd2;
  localparam logic [2:0] BUS_ACK    = 3'd3;
  localparam logic [2:0] BUS_END    = 3'd4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  function automatic logic [7:0] status_byte(input logic busy, input logic cs);
    status_byte = 8'h00;
    status_byte[ST_BUSY] = busy;
    status_byte[ST_CS] = cs;
  endfunction
endpackage

// File: rtl/sdio_spi_ctrl_if.sv
// sdio_spi_ctrl_if: 68000-side bus signals of the SDIO SPI controller.
interface sdio_spi_ctrl_if;
  logic       SDIO_ACCESS, AS_n, DS_n, RW_n;
  logic [1:0] A_REG;
  logic [7:0] D_IN, D_OUT;
  logic       D_OE, DTACK_n;
  modport master (output SDIO_ACCESS, AS_n, DS_n, RW_n, A_REG, D_IN, input D_OUT, D_OE, DTACK_n);
  modport slave  (input SDIO_ACCESS, AS_n, DS_n, RW_n, A_REG, D_IN, output D_OUT, D_OE, DTACK_n);
endinterface

// File: rtl/sdio_spi_shift.sv
// sdio_spi_shift: mode-0 MSB-first 8-bit SPI shifter with programmable half-period.
module sdio_spi_shift
  import sdio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic [7:0] div_i,
  input  logic       miso_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sck_o,
  output logic       mosi_o,
  output logic [7:0] rx_o
);
  logic [1:0] st_q, st_d;
  logic [7:0] cnt_q, cnt_d, hdiv_q, hdiv_d, sh_q, sh_d, rx_q, rx_d;
  logic [2:0] bit_q, bit_d;
  logic       sck_q, sck_d, mosi_q, mosi_d, tick;
  assign tick = cnt_q == hdiv_q;
  assign done_o = st_q == S_HIGH && tick && bit_q == 3'd7;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    hdiv_d = hdiv_q;
    sh_d = sh_q;
    rx_d = rx_q;
    bit_d = bit_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    case (st_q)
      S_IDLE: if (start_i) begin
        st_d = S_LOW;
        sh_d = tx_i;
        mosi_d = tx_i[7];
        hdiv_d = div_i;
        cnt_d = '0;
        bit_d = '0;
      end
      S_LOW: if (tick) begin
        st_d = S_HIGH;
        sck_d = 1'b1;
        rx_d = {rx_q[6:0], miso_i};
        cnt_d = '0;
      end else cnt_d = cnt_q + 8'd1;
      S_HIGH: if (tick) begin
        st_d = done_o ? S_IDLE : S_LOW;
        sck_d = 1'b0;
        sh_d = {sh_q[6:0], 1'b1};
        mosi_d = done_o ? 1'b1 : sh_q[6];
        bit_d = bit_q + 3'd1;
        cnt_d = '0;
      end else cnt_d = cnt_q + 8'd1;
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      hdiv_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      bit_q <= '0;
      sck_q <= 1'b0;
      mosi_q <= 1'b1;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      hdiv_q <= hdiv_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
    end
  assign busy_o = st_q != S_IDLE;
  assign sck_o = sck_q;
  assign mosi_o = mosi_q;
  assign rx_o = rx_q;
endmodule

// File: rtl/sdio_spi_ctrl.sv
// sdio_spi_ctrl: 68000 bus slave exposing DATA/STATUS/CONTROL/DIVIDER registers of an SPI SD-card port.
module sdio_spi_ctrl
  import sdio_pkg::*;
#(
  parameter logic [7:0] DIV_RESET = 8'd17,
  parameter int         ACK_DELAY = 2
) (
  input  logic C7M,
  input  logic RESET,
  sdio_spi_ctrl_if.slave bus,
  output logic SPI_SCK,
  output logic SPI_MOSI,
  output logic SPI_CS_n,
  input  logic SPI_MISO
);
  logic [1:0] as_sq, ds_sq, acc_sq;
  logic [2:0] st_q, st_d;
  logic [7:0] cnt_q, cnt_d, div_q, data_q, dout_q, rdata, rx;
  logic       ctrl_q, doe_q, dtack_q;
  logic       as_s, ds_s, acc_s, busy, done, ack_entry, wr, start, is_data;
  assign as_s = as_sq[1];
  assign ds_s = ds_sq[1];
  assign acc_s = acc_sq[1];
  assign is_data = bus.A_REG == REG_DATA;
  assign ack_entry = st_d == BUS_ACK;
  assign wr = ack_entry && !bus.RW_n;
  assign start = wr && is_data;
  assign rdata = is_data ? data_q :
                 bus.A_REG == REG_STATUS ? status_byte(busy, ctrl_q) :
                 bus.A_REG == REG_CTRL ? {7'b0, ctrl_q} : div_q;
  // Only DATA accesses stall on a running transfer; CONTROL/DIVIDER/STATUS always ack promptly.
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    case (st_q)
      BUS_IDLE: if (acc_s && !ds_s) begin
        st_d = BUS_DECODE;
        cnt_d = '0;
      end
      BUS_DECODE: if (as_s) st_d = BUS_IDLE;
        else if (cnt_q == 8'(ACK_DELAY - 1)) st_d = (is_data && busy) ? BUS_WAIT : BUS_ACK;
        else cnt_d = cnt_q + 8'd1;
      BUS_WAIT: st_d = as_s ? BUS_IDLE : busy ? BUS_WAIT : BUS_ACK;
      BUS_ACK: st_d = BUS_END;
      BUS_END: st_d = as_s ? BUS_IDLE : BUS_END;
      default: st_d = BUS_IDLE;
    endcase
  end
  always_ff @(posedge C7M or posedge RESET)
    if (RESET) begin
      as_sq <= 2'b11;
      ds_sq <= 2'b11;
      acc_sq <= 2'b00;
      st_q <= BUS_IDLE;
      cnt_q <= '0;
      ctrl_q <= 1'b0;
      div_q <= DIV_RESET;
      data_q <= 8'hFF;
      dout_q <= '0;
      doe_q <= 1'b0;
      dtack_q <= 1'b1;
    end else begin
      as_sq <= {as_sq[0], bus.AS_n};
      ds_sq <= {ds_sq[0], bus.DS_n};
      acc_sq <= {acc_sq[0], bus.SDIO_ACCESS};
      st_q <= st_d;
      cnt_q <= cnt_d;
      if (wr && bus.A_REG == REG_CTRL) ctrl_q <= bus.D_IN[0];
      if (wr && bus.A_REG == REG_DIV) div_q <= bus.D_IN;
      if (done) data_q <= rx;
      if (ack_entry) begin
        dtack_q <= 1'b0;
        doe_q <= bus.RW_n;
        dout_q <= rdata;
      end else if (st_q == BUS_END && as_s) begin
        dtack_q <= 1'b1;
        doe_q <= 1'b0;
      end
    end
  sdio_spi_shift u_shift (
    .clk(C7M), .rst(RESET), .start_i(start), .tx_i(bus.D_IN), .div_i(div_q),
    .miso_i(SPI_MISO), .busy_o(busy), .done_o(done), .sck_o(SPI_SCK),
    .mosi_o(SPI_MOSI), .rx_o(rx)
  );
  assign SPI_CS_n = ~ctrl_q;
  assign bus.D_OUT = dout_q;
  assign bus.D_OE = doe_q;
  assign bus.DTACK_n = dtack_q;
endmodule

// File: tb/tb_sdio_spi_ctrl.sv
// tb_sdio_spi_ctrl: directed bus cycles against sdio_spi_ctrl with MISO looped back to MOSI.
module tb_sdio_spi_ctrl;
  import sdio_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic sck, mosi, cs_n;
  int n_ass = 0, n_fail = 0, lat = 0, pul_ack = 0, pulses = 0, hi_cnt = 0;
  int p0, h0, k;
  logic [7:0] rd_q, mosi_log = 8'h00;
  sdio_spi_ctrl_if bif();
  sdio_spi_ctrl dut (.C7M(clk), .RESET(rst), .bus(bif), .SPI_SCK(sck), .SPI_MOSI(mosi),
                     .SPI_CS_n(cs_n), .SPI_MISO(mosi));
  always #5 clk = ~clk;
  always @(posedge sck) begin
    pulses <= pulses + 1;
    mosi_log <= {mosi_log[6:0], mosi};
  end
  always @(negedge clk) if (sck) hi_cnt <= hi_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_ass++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bus_cyc(input logic rw, input logic [1:0] a, input logic [7:0] d);
    int r;
    @(negedge clk);
    bif.A_REG = a; bif.RW_n = rw; bif.D_IN = d; bif.AS_n = 1'b0; bif.SDIO_ACCESS = 1'b1;
    @(negedge clk);
    bif.DS_n = 1'b0;
    lat = 0;
    while (bif.DTACK_n && lat < 500) begin @(negedge clk); lat++; end
    pul_ack = pulses;
    rd_q = bif.D_OUT;
    chk("dtack_seen", 32'(lat < 500), 1);
    if (rw) chk("rd_oe", 32'(bif.D_OE), 1);
    bif.AS_n = 1'b1; bif.DS_n = 1'b1; bif.SDIO_ACCESS = 1'b0;
    r = 0;
    while (!bif.DTACK_n && r < 20) begin @(negedge clk); r++; end
    chk("dtack_release", 32'(bif.DTACK_n), 1);
    chk("oe_release", 32'(bif.D_OE), 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus_cyc(1'b0, a, d);
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus_cyc(1'b1, a, 8'h00);
    chk(tag, 32'(rd_q), 32'(exp));
  endtask
  initial begin
    bif.SDIO_ACCESS = 1'b0; bif.AS_n = 1'b1; bif.DS_n = 1'b1; bif.RW_n = 1'b1;
    bif.A_REG = 2'd0; bif.D_IN = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_dtack", 32'(bif.DTACK_n), 1);
    chk("rst_oe", 32'(bif.D_OE), 0);
    chk("rst_dout", 32'(bif.D_OUT), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 1);
    rd("rst_status", REG_STATUS, 8'h00);
    rd("rst_div", REG_DIV, 8'd17);
    rd("rst_data", REG_DATA, 8'hFF);
    rd("rst_ctrl", REG_CTRL, 8'h00);
    // basic transfer at the fastest clock
    wr(REG_CTRL, 8'h01);
    chk("cs_on", 32'(cs_n), 0);
    rd("status_cs", REG_STATUS, 8'h40);
    wr(REG_DIV, 8'h00);
    rd("div_rb", REG_DIV, 8'h00);
    p0 = pulses; h0 = hi_cnt;
    wr(REG_DATA, 8'hA5);
    repeat (30) @(negedge clk);
    chk("a5_pulses", 32'(pulses - p0), 8);
    chk("a5_sck_high", 32'(hi_cnt - h0), 8);
    chk("a5_mosi", 32'(mosi_log), 32'h A5);
    rd("a5_data", REG_DATA, 8'hA5);
    rd("a5_status", REG_STATUS, 8'h40);
    // DATA write while busy waits for the first byte to finish
    wr(REG_DIV, 8'h03);
    p0 = pulses;
    wr(REG_DATA, 8'h3C);
    wr(REG_DATA, 8'hC3);
    chk("wait_first_done", 32'(pul_ack - p0), 8);
    chk("wait_long", 32'(lat > 20), 1);
    repeat (80) @(negedge clk);
    chk("c3_pulses", 32'(pulses - p0), 16);
    chk("c3_mosi", 32'(mosi_log), 32'hC3);
    rd("c3_data", REG_DATA, 8'hC3);
    // CONTROL/DIVIDER during a transfer: immediate ack, CS changes now, divider later
    p0 = pulses; h0 = hi_cnt;
    wr(REG_DATA, 8'h81);
    wr(REG_CTRL, 8'h00);
    chk("ctrl_busy_lat", 32'(lat), 5);
    chk("ctrl_busy_cs", 32'(cs_n), 1);
    wr(REG_DIV, 8'h00);
    repeat (80) @(negedge clk);
    chk("81_sck_high", 32'(hi_cnt - h0), 32);
    chk("81_mosi", 32'(mosi_log), 32'h81);
    wr(REG_CTRL, 8'h01);
    // STATUS read mid-transfer
    wr(REG_DIV, 8'h03);
    wr(REG_DATA, 8'h5A);
    rd("status_busy", REG_STATUS, 8'hC0);
    chk("status_busy_lat", 32'(lat), 5);
    repeat (80) @(negedge clk);
    rd("5a_data", REG_DATA, 8'h5A);
    rd("5a_status", REG_STATUS, 8'h40);
    // aborted DIVIDER write
    @(negedge clk);
    bif.A_REG = REG_DIV; bif.RW_n = 1'b0; bif.D_IN = 8'h55;
    bif.AS_n = 1'b0; bif.SDIO_ACCESS = 1'b1; bif.DS_n = 1'b0;
    repeat (2) @(negedge clk);
    bif.AS_n = 1'b1; bif.SDIO_ACCESS = 1'b0; bif.DS_n = 1'b1;
    k = 0;
    repeat (20) begin @(negedge clk); if (!bif.DTACK_n) k++; end
    chk("abort_no_dtack", 32'(k), 0);
    rd("abort_div", REG_DIV, 8'h03);
    rd("abort_status", REG_STATUS, 8'h40);
    // reset in the middle of a byte
    p0 = pulses;
    wr(REG_DATA, 8'h0F);
    k = 0;
    while ((pulses - p0 < 2 || sck) && k < 200) begin @(negedge clk); k++; end
    chk("mid_reach", 32'(k < 200), 1);
    chk("mid_mosi_pre", 32'(mosi), 0);
    rst = 1'b1;
    #1;
    chk("mid_sck", 32'(sck), 0);
    chk("mid_mosi", 32'(mosi), 1);
    chk("mid_cs_n", 32'(cs_n), 1);
    chk("mid_dtack", 32'(bif.DTACK_n), 1);
    @(negedge clk);
    rst = 1'b0;
    rd("mid_status", REG_STATUS, 8'h00);
    rd("mid_data", REG_DATA, 8'hFF);
    rd("mid_div", REG_DIV, 8'd17);
    wr(REG_CTRL, 8'h01);
    wr(REG_DIV, 8'h00);
    p0 = pulses;
    wr(REG_DATA, 8'h69);
    repeat (30) @(negedge clk);
    chk("69_pulses", 32'(pulses - p0), 8);
    chk("69_mosi", 32'(mosi_log), 32'h69);
    rd("69_data", REG_DATA, 8'h69);
    $display("End of test - %0d assertions evaluated, %0d failures", n_ass, n_fail);
    $finish;
  end
endmodule
